i2s_frame_scheduler: RTL and testbench



---
 rtl/adat_i2s_pkg.sv | 14 +
 rtl/holdoff_timer.sv | 26 ++
 rtl/i2s_frame_scheduler.sv | 122 ++++++++++++
 tb/tb_i2s_frame_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adat_i2s_pkg.sv
// Shared types and constants for the ADAT-to-I2S frame path.
package adat_i2s_pkg;

   localparam int CIRC_BUF_BITS_DEFAULT = 3;
   localparam int FRAME_BITS            = 256;

   typedef enum logic [1:0] {
      StIdle,
      StPriming,
      StRunning,
      StRecover
   } sched_state_e;

endpackage

// File: rtl/holdoff_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module holdoff_timer #(
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Write-side slot tracking and transmitter enable for the circular I2S frame buffer.
module i2s_frame_scheduler
   import adat_i2s_pkg::*;
#(
   parameter int CIRC_BUF_BITS  = CIRC_BUF_BITS_DEFAULT,
   parameter int LOCK_FRAMES    = 4,
   parameter int HOLDOFF_CYCLES = 2048
) (
   input  logic                     clk_x4_i,
   input  logic                     rst_i,
   input  logic                     adat_locked_i,
   input  logic                     frame_done_i,
   input  logic                     frame_error_i,
   input  logic [CIRC_BUF_BITS-1:0] rd_frame_i,
   output logic [CIRC_BUF_BITS-1:0] wr_frame_o,
   output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
   output logic                     resync_req_o,
   output logic [CIRC_BUF_BITS-1:0] fill_level_o,
   output logic [7:0]               slip_count_o
);

   localparam int                     HOLD_W    = $clog2(HOLDOFF_CYCLES);
   localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
   localparam logic [7:0]             LOCK_MAX  = 8'(LOCK_FRAMES);
   localparam logic [CIRC_BUF_BITS-1:0] SLOT_ONE = CIRC_BUF_BITS'(1);

   sched_state_e             state_reg, state_next;
   logic [CIRC_BUF_BITS-1:0] wr_reg, wr_next;
   logic [CIRC_BUF_BITS-1:0] lgf_reg, lgf_next;
   logic [7:0]               good_reg, good_next;
   logic [7:0]               slip_reg, slip_next;
   logic                     resync_reg;
   logic [CIRC_BUF_BITS-1:0] wr_inc;
   logic                     good_done;
   logic                     overrun;
   logic                     timer_load;
   logic                     timer_done;

   assign wr_inc    = wr_reg + SLOT_ONE;
   assign good_done = adat_locked_i && frame_done_i && !frame_error_i;
   assign overrun   = good_done && (wr_inc == rd_frame_i);

   // Slot accounting is state independent; a bad frame keeps the writer on the same slot.
   always_comb begin
      wr_next   = wr_reg;
      lgf_next  = lgf_reg;
      good_next = good_reg;
      if (!adat_locked_i || frame_error_i) begin
         good_next = '0;
      end else if (frame_done_i) begin
         lgf_next = wr_reg;
         wr_next  = wr_inc;
         if (good_reg < LOCK_MAX) begin
            good_next = good_reg + 8'd1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         StIdle: begin
            if (adat_locked_i) state_next = StPriming;
         end
         StPriming: begin
            if (!adat_locked_i)              state_next = StIdle;
            else if (good_next >= LOCK_MAX)  state_next = StRunning;
         end
         StRunning: begin
            if (!adat_locked_i || frame_error_i || overrun) state_next = StRecover;
         end
         StRecover: begin
            if (timer_done) state_next = StIdle;
         end
         default: state_next = StIdle;
      endcase
   end

   assign timer_load = (state_next == StRecover) && (state_reg != StRecover);

   always_comb begin
      slip_next = slip_reg;
      if (timer_load && slip_reg != 8'hFF) begin
         slip_next = slip_reg + 8'd1;
      end
   end

   always_ff @(posedge clk_x4_i) begin
      if (rst_i) begin
         state_reg  <= StIdle;
         wr_reg     <= '0;
         lgf_reg    <= '0;
         good_reg   <= '0;
         slip_reg   <= '0;
         resync_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         wr_reg     <= wr_next;
         lgf_reg    <= lgf_next;
         good_reg   <= good_next;
         slip_reg   <= slip_next;
         resync_reg <= (state_next == StRunning);
      end
   end

   holdoff_timer #(
      .WIDTH(HOLD_W)
   ) u_holdoff (
      .clk       (clk_x4_i),
      .srst      (rst_i),
      .load      (timer_load),
      .load_value(HOLD_LOAD),
      .done      (timer_done)
   );

   assign wr_frame_o            = wr_reg;
   assign last_good_frame_idx_o = lgf_reg;
   assign resync_req_o          = resync_reg;
   assign slip_count_o          = slip_reg;
   assign fill_level_o          = wr_reg - rd_frame_i;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Scoreboard bench for i2s_frame_scheduler: expectations queued with each stimulus cycle, drained after the edge.
module tb_i2s_frame_scheduler;

   localparam int N    = 3;
   localparam int LOCK = 4;
   // Short holdoff keeps 256 back-to-back recoveries within a small cycle budget.
   localparam int HOLD = 16;

   localparam int S_WR = 0, S_LGF = 1, S_RS = 2, S_FILL = 3, S_SLIP = 4;

   logic         clk = 1'b0;
   logic         rst, lock, done, err;
   logic [N-1:0] rd, wr, lgf, fill;
   logic         resync;
   logic [7:0]   slip;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string tag;
      int    sel;
      int    val;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   i2s_frame_scheduler #(
      .CIRC_BUF_BITS (N),
      .LOCK_FRAMES   (LOCK),
      .HOLDOFF_CYCLES(HOLD)
   ) dut (
      .clk_x4_i             (clk),
      .rst_i                (rst),
      .adat_locked_i        (lock),
      .frame_done_i         (done),
      .frame_error_i        (err),
      .rd_frame_i           (rd),
      .wr_frame_o           (wr),
      .last_good_frame_idx_o(lgf),
      .resync_req_o         (resync),
      .fill_level_o         (fill),
      .slip_count_o         (slip)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   function automatic logic [31:0] sample(input int sel);
      case (sel)
         S_WR:    return 32'(wr);
         S_LGF:   return 32'(lgf);
         S_RS:    return 32'(resync);
         S_FILL:  return 32'(fill);
         S_SLIP:  return 32'(slip);
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic expect_out(input string tag, input int sel, input int val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_val(e.tag, sample(e.sel), 32'(e.val));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic cycle(input logic d, input logic e);
      done = d;
      err  = e;
      if (d || e)
         $display("strobe done=%0b err=%0b lock=%0b rd=%0d wr_before=%0d", d, e, lock, rd, wr);
      tick();
      done = 1'b0;
      err  = 1'b0;
   endtask

   task automatic expect_reset(input string tag);
      expect_out({tag, "_wr"},   S_WR,   0);
      expect_out({tag, "_lgf"},  S_LGF,  0);
      expect_out({tag, "_rs"},   S_RS,   0);
      expect_out({tag, "_slip"}, S_SLIP, 0);
      expect_out({tag, "_fill"}, S_FILL, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst = 1'b1; lock = 1'b0; done = 1'b0; err = 1'b0; rd = '0;
      tick();
      expect_reset("reset");
      tick();
      rst = 1'b0;

      // Lock and prime with four good frames.
      lock = 1'b1;
      expect_out("idle_rs", S_RS, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         expect_out("prime_wr",  S_WR,  i + 1);
         expect_out("prime_lgf", S_LGF, i);
         expect_out("prime_rs",  S_RS,  (i == 3) ? 1 : 0);
         cycle(1'b1, 1'b0);
      end

      // Walk wr to 1 with rd=2, then overrun.
      rd = 3'd2;
      for (int i = 0; i < 5; i++) begin
         w = (5 + i) % 8;
         expect_out("run_wr",   S_WR,   w);
         expect_out("run_fill", S_FILL, (w + 6) % 8);
         expect_out("run_rs",   S_RS,   1);
         cycle(1'b1, 1'b0);
      end
      expect_out("ovr_rs",   S_RS,   0);
      expect_out("ovr_slip", S_SLIP, 1);
      expect_out("ovr_wr",   S_WR,   2);
      expect_out("ovr_lgf",  S_LGF,  1);
      cycle(1'b1, 1'b0);
      // Holdoff cycles plus the Idle and Priming passes before re-enable.
      for (int k = 1; k <= HOLD + 1; k++) begin
         expect_out("hold_rs", S_RS, 0);
         tick();
      end
      expect_out("hold_end_rs", S_RS, 1);
      tick();

      // Done and error together at wr=5.
      rd = 3'd0;
      for (int i = 0; i < 3; i++) begin
         expect_out("pre_err_wr", S_WR, 3 + i);
         cycle(1'b1, 1'b0);
      end
      expect_out("both_wr",   S_WR,   5);
      expect_out("both_lgf",  S_LGF,  4);
      expect_out("both_rs",   S_RS,   0);
      expect_out("both_slip", S_SLIP, 2);
      cycle(1'b1, 1'b1);
      tick(); tick(); tick();

      // Reset in the middle of the holdoff.
      rst = 1'b1;
      expect_reset("midhold");
      tick();
      rst = 1'b0;

      // Nine good frames wrap the write slot.
      rd = 3'd3;
      for (int i = 0; i < 9; i++) begin
         expect_out("wrap_wr",  S_WR,  (i + 1) % 8);
         expect_out("wrap_lgf", S_LGF, i % 8);
         expect_out("wrap_rs",  S_RS,  (i >= 3) ? 1 : 0);
         cycle(1'b1, 1'b0);
      end
      rd = 3'd6;
      expect_out("wrap_fill", S_FILL, 3);
      expect_out("wrap_hold_rs", S_RS, 1);
      tick();

      // Lock loss while priming discards the partial count.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rd = 3'd0;
      for (int i = 0; i < 3; i++) begin
         expect_out("p3_wr", S_WR, i + 1);
         expect_out("p3_rs", S_RS, 0);
         cycle(1'b1, 1'b0);
      end
      lock = 1'b0;
      expect_out("unlock_wr", S_WR, 3);
      expect_out("unlock_rs", S_RS, 0);
      cycle(1'b1, 1'b0);
      lock = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_out("relock_wr", S_WR, 4 + i);
         expect_out("relock_rs", S_RS, (i == 3) ? 1 : 0);
         cycle(1'b1, 1'b0);
      end

      // 256 recoveries saturate the slip counter.
      for (int i = 0; i < 256; i++) begin
         expect_out("sat_slip", S_SLIP, (i + 1 > 255) ? 255 : i + 1);
         expect_out("sat_rs",   S_RS,   0);
         cycle(1'b0, 1'b1);
         for (int f = 0; f < 4; f++) cycle(1'b1, 1'b0);
         for (int k = 0; k < HOLD + 10 && resync !== 1'b1; k++) tick();
         expect_out("sat_relock", S_RS, 1);
         drain();
         $display("recovery %0d slip=%0d", i, slip);
      end
      expect_out("sat_final", S_SLIP, 255);
      cycle(1'b0, 1'b1);
      tick(); tick(); tick(); tick(); tick();
      rst = 1'b1;
      expect_reset("final_rst");
      tick();
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
